// File: rtl/logsys_btn_debounce.sv
// Push-button conditioner for the LOGSYS Spartan-6 simple I/O peripheral.
// Each pin is synchronised, debounced on a shared 1 kHz tick and turned into
// a clean level plus one-cycle press / release / auto-repeat event pulses.
// Everything runs in the Bus2IP_Clk domain.

// Per-button lane: synchroniser, debounce counter and auto-repeat FSM.
module logsys_btn_debounce_lane #(
  parameter int DEBOUNCE   = 10,
  parameter int DELAY      = 500,
  parameter int RATE       = 100,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic tick_i,
  input  logic repeat_en_i,
  output logic out_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int   DCW   = $clog2(DEBOUNCE + 1);
  localparam int   RMAX  = (DELAY > RATE) ? DELAY : RATE;
  localparam int   RCW   = $clog2(RMAX + 1);
  // Synchroniser resets to the electrically inactive pin level so the
  // post-polarity value starts at "not pressed".
  localparam logic INACT = ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REPEAT
  } rpt_st_e;

  logic           s1_q, s2_q, s;
  logic           out_q, out_d;
  logic [DCW-1:0] dc_q, dc_d, dc_inc;
  logic           press_q, press_d;
  logic           release_q, release_d;
  rpt_st_e        st_q;
  logic [RCW-1:0] rc_q, rc_inc;
  logic           rep_q;

  // Two-flop synchroniser on the asynchronous pin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= INACT;
      s2_q <= INACT;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Polarity fix-up after the second flop: s = 1 means pressed.
  assign s = s2_q ^ INACT;

  // Debounce next state: count consecutive ticks on which s differs from the
  // accepted level; any agreeing tick restarts the count.
  always_comb begin
    dc_inc    = dc_q + DCW'(1);
    dc_d      = dc_q;
    out_d     = out_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick_i) begin
      if (s != out_q) begin
        if (dc_inc == DCW'(DEBOUNCE)) begin
          dc_d      = '0;
          out_d     = ~out_q;
          press_d   = ~out_q;
          release_d = out_q;
        end else begin
          dc_d = dc_inc;
        end
      end else begin
        dc_d = '0;
      end
    end
  end

  // Debounce state and edge pulses, updated on the same edge as the level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q     <= 1'b0;
      dc_q      <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      dc_q      <= dc_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign rc_inc = rc_q + RCW'(1);

  // Auto-repeat FSM. It leaves IDLE on the edge that raises the level, so the
  // press tick itself is not counted and the first repeat lands exactly
  // DELAY ticks later. A falling level wins over a repeat due on that tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q  <= ST_IDLE;
      rc_q  <= '0;
      rep_q <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (release_d) begin
        st_q <= ST_IDLE;
        rc_q <= '0;
      end else begin
        case (st_q)
          ST_IDLE: begin
            if (press_d) begin
              st_q <= ST_WAIT;
              rc_q <= '0;
            end
          end
          ST_WAIT: begin
            if (!repeat_en_i) begin
              rc_q <= '0;
            end else if (tick_i) begin
              if (rc_inc == RCW'(DELAY)) begin
                rep_q <= 1'b1;
                rc_q  <= '0;
                st_q  <= ST_REPEAT;
              end else begin
                rc_q <= rc_inc;
              end
            end
          end
          ST_REPEAT: begin
            if (!repeat_en_i) begin
              // Dropping the enable re-arms the full initial delay.
              st_q <= ST_WAIT;
              rc_q <= '0;
            end else if (tick_i) begin
              if (rc_inc == RCW'(RATE)) begin
                rep_q <= 1'b1;
                rc_q  <= '0;
              end else begin
                rc_q <= rc_inc;
              end
            end
          end
          default: begin
            st_q <= ST_IDLE;
            rc_q <= '0;
          end
        endcase
      end
    end
  end

  assign out_o     = out_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = rep_q;

endmodule

// Top: shared 1 kHz prescaler plus one lane per button.
module logsys_btn_debounce #(
  parameter int C_CLK_FREQ_HZ     = 50000000,
  parameter int C_NUM_BTN         = 3,
  parameter int C_BTN_ACTIVE_LOW  = 0,
  parameter int C_DEBOUNCE_MS     = 10,
  parameter int C_REPEAT_DELAY_MS = 500,
  parameter int C_REPEAT_RATE_MS  = 100
) (
  input  logic                 Bus2IP_Clk,
  input  logic                 Bus2IP_Resetn,
  input  logic [C_NUM_BTN-1:0] btn_raw,
  input  logic                 repeat_en,
  output logic [C_NUM_BTN-1:0] btn_out,
  output logic [C_NUM_BTN-1:0] btn_press,
  output logic [C_NUM_BTN-1:0] btn_release,
  output logic [C_NUM_BTN-1:0] btn_repeat,
  output logic                 tick
);

  localparam int DIV = C_CLK_FREQ_HZ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc_q;

  // Down-counting prescaler; tick is the cycle it sits at zero, so the
  // first tick is consumed on the DIV-th edge after reset release.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      presc_q <= PW'(DIV - 1);
    end else if (presc_q == '0) begin
      presc_q <= PW'(DIV - 1);
    end else begin
      presc_q <= presc_q - PW'(1);
    end
  end

  assign tick = (presc_q == '0);

  for (genvar i = 0; i < C_NUM_BTN; i++) begin : g_lane
    logsys_btn_debounce_lane #(
      .DEBOUNCE   (C_DEBOUNCE_MS),
      .DELAY      (C_REPEAT_DELAY_MS),
      .RATE       (C_REPEAT_RATE_MS),
      .ACTIVE_LOW (C_BTN_ACTIVE_LOW != 0)
    ) u_lane (
      .clk_i       (Bus2IP_Clk),
      .rst_ni      (Bus2IP_Resetn),
      .raw_i       (btn_raw[i]),
      .tick_i      (tick),
      .repeat_en_i (repeat_en),
      .out_o       (btn_out[i]),
      .press_o     (btn_press[i]),
      .release_o   (btn_release[i]),
      .repeat_o    (btn_repeat[i])
    );
  end

endmodule
